// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative shift-add multiplier.
// Single-cycle ops complete in one cycle; MUL occupies the block for WIDTH+1 cycles.
//
// state | meaning
// IDLE  | empty, ready to accept
// MUL   | shift-add multiply in progress, count steps remaining
// DONE  | result and flags held on Y/flag_* until out_ready
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Op_code,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_STEPS = CW'(WIDTH);

    localparam logic [3:0] OP_PASS_A = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_OR     = 4'h4;
    localparam logic [3:0] OP_INC    = 4'h5;
    localparam logic [3:0] OP_DEC    = 4'h6;
    localparam logic [3:0] OP_PASS_B = 4'h7;
    localparam logic [3:0] OP_XOR    = 4'h8;
    localparam logic [3:0] OP_SHL    = 4'h9;
    localparam logic [3:0] OP_SHR    = 4'hA;
    localparam logic [3:0] OP_SRA    = 4'hB;
    localparam logic [3:0] OP_MUL    = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic               accept;
    logic               is_mul;
    logic [WIDTH-1:0]   arith_b;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   res_y;
    logic               res_c;
    logic               res_v;
    logic               res_err;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (Op_code == OP_MUL);

    // INC/DEC reuse the adder/subtractor with a constant 1, so carry and overflow fall out the same way
    assign arith_b = ((Op_code == OP_INC) || (Op_code == OP_DEC)) ? WIDTH'(1) : B;
    assign add_ext = {1'b0, A} + {1'b0, arith_b};
    assign sub_ext = {1'b0, A} - {1'b0, arith_b};
    assign shamt   = B[SHW-1:0];

    always_comb begin
        res_y   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        case (Op_code)
            OP_PASS_A: res_y = A;
            OP_ADD, OP_INC: begin
                res_y = add_ext[WIDTH-1:0];
                res_c = add_ext[WIDTH];
                res_v = (A[WIDTH-1] == arith_b[WIDTH-1]) && (res_y[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                res_y = sub_ext[WIDTH-1:0];
                res_c = sub_ext[WIDTH];
                res_v = (A[WIDTH-1] != arith_b[WIDTH-1]) && (res_y[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:    res_y = A & B;
            OP_OR:     res_y = A | B;
            OP_PASS_B: res_y = B;
            OP_XOR:    res_y = A ^ B;
            OP_SHL:    res_y = A << shamt;
            OP_SHR:    res_y = A >> shamt;
            OP_SRA:    res_y = $unsigned($signed(A) >>> shamt);
            OP_MUL:    res_y = '0;
            default:   res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_mul ? MUL : DONE;
                end
            end
            MUL: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = is_mul ? MUL : DONE;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y        <= '0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            flag_err <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= {{WIDTH{1'b0}}, A};
                mplier <= B;
                acc    <= '0;
                count  <= MUL_STEPS;
            end else begin
                Y        <= res_y;
                flag_z   <= (res_y == '0);
                flag_n   <= res_y[WIDTH-1];
                flag_c   <= res_c;
                flag_v   <= res_v;
                flag_err <= res_err;
            end
        end else if (state == MUL) begin
            if (count != '0) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - 1'b1;
            end else begin
                // low half is the result; any set bit in the high half means the product overflowed
                Y        <= acc[WIDTH-1:0];
                flag_z   <= (acc[WIDTH-1:0] == '0);
                flag_n   <= acc[WIDTH-1];
                flag_c   <= |acc[2*WIDTH-1:WIDTH];
                flag_v   <= 1'b0;
                flag_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8: arithmetic flags, shifts, multiply latency,
// back-to-back throughput, output back-pressure, illegal opcode and mid-multiply reset.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   Op_code;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Y;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         flag_v;
    logic         flag_err;

    int vectors;
    int miscompares;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Op_code   (Op_code),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_err  (flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {err, v, c, n, z}
    function automatic logic [7:0] flags();
        return {3'b000, flag_err, flag_v, flag_c, flag_n, flag_z};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present an op, wait (bounded) for in_ready, return #1 after the acceptance edge
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        Op_code  = op;
        A        = a;
        B        = b;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        chk("issue_ready", {7'd0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int waited;
        waited = 0;
        while (!out_valid && waited < 40) begin
            tick();
            waited++;
        end
        chk(tag, {7'd0, out_valid}, 8'h01);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        Op_code   = 4'h0;
        A         = '0;
        B         = '0;
        out_ready = 1'b1;

        #12;
        chk("rst_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_y", Y, 8'h00);
        chk("rst_flags", flags(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {7'd0, in_ready}, 8'h01);

        // carry out and zero
        issue(4'h1, 8'hFF, 8'h01);
        chk("add1_valid", {7'd0, out_valid}, 8'h01);
        chk("add1_y", Y, 8'h00);
        chk("add1_flags", flags(), 8'h05);
        // signed overflow
        issue(4'h1, 8'h7F, 8'h01);
        chk("add2_y", Y, 8'h80);
        chk("add2_flags", flags(), 8'h0A);

        // borrow
        issue(4'h2, 8'h00, 8'h01);
        chk("sub_y", Y, 8'hFF);
        chk("sub_flags", flags(), 8'h06);
        issue(4'h6, 8'h80, 8'h00);
        chk("dec_y", Y, 8'h7F);
        chk("dec_flags", flags(), 8'h08);
        issue(4'h5, 8'hFF, 8'h00);
        chk("inc_y", Y, 8'h00);
        chk("inc_flags", flags(), 8'h05);

        // shifts use only B[2:0]
        issue(4'hB, 8'h90, 8'hF3);
        chk("sra_y", Y, 8'hF2);
        chk("sra_flags", flags(), 8'h02);
        issue(4'hA, 8'h90, 8'hF3);
        chk("shr_y", Y, 8'h12);
        chk("shr_flags", flags(), 8'h00);
        issue(4'h9, 8'h81, 8'h01);
        chk("shl_y", Y, 8'h02);
        chk("shl_flags", flags(), 8'h00);

        // multiply: busy 8 cycles, out_valid on the 9th edge after acceptance
        tick();
        issue(4'hC, 8'd20, 8'd13);
        for (int i = 0; i < 8; i++) begin
            chk("mul_busy_ready", {7'd0, in_ready}, 8'h00);
            chk("mul_busy_valid", {7'd0, out_valid}, 8'h00);
            tick();
        end
        chk("mul_pre_valid", {7'd0, out_valid}, 8'h00);
        tick();
        chk("mul_lat_valid", {7'd0, out_valid}, 8'h01);
        chk("mul1_y", Y, 8'h04);
        chk("mul1_flags", flags(), 8'h04);
        issue(4'hC, 8'd3, 8'd5);
        wait_valid("mul2_valid");
        chk("mul2_y", Y, 8'h0F);
        chk("mul2_flags", flags(), 8'h00);
        issue(4'hC, 8'h00, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            chk("mul0_busy", {7'd0, out_valid}, 8'h00);
            tick();
        end
        tick();
        chk("mul0_valid", {7'd0, out_valid}, 8'h01);
        chk("mul0_flags", flags(), 8'h01);

        // back-to-back single-cycle ops, one result per cycle in order
        tick();
        tick();
        in_valid = 1'b1;
        Op_code = 4'h1; A = 8'h10; B = 8'h20;
        tick();
        chk("b2b0_valid", {7'd0, out_valid}, 8'h01);
        chk("b2b0_y", Y, 8'h30);
        Op_code = 4'h8; A = 8'hF0; B = 8'h3C;
        tick();
        chk("b2b1_valid", {7'd0, out_valid}, 8'h01);
        chk("b2b1_y", Y, 8'hCC);
        Op_code = 4'h4; A = 8'h01; B = 8'h02;
        tick();
        chk("b2b2_valid", {7'd0, out_valid}, 8'h01);
        chk("b2b2_y", Y, 8'h03);
        Op_code = 4'h7; A = 8'h00; B = 8'h55;
        tick();
        in_valid = 1'b0;
        chk("b2b3_valid", {7'd0, out_valid}, 8'h01);
        chk("b2b3_y", Y, 8'h55);
        tick();
        chk("b2b_drain", {7'd0, out_valid}, 8'h00);

        // back-pressure: result held, new op stalled, then accepted alongside the drain
        out_ready = 1'b0;
        issue(4'h1, 8'h01, 8'h01);
        in_valid = 1'b1;
        Op_code = 4'h2; A = 8'h09; B = 8'h01;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", {7'd0, out_valid}, 8'h01);
            chk("hold_y", Y, 8'h02);
            chk("hold_ready", {7'd0, in_ready}, 8'h00);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("drain_ready", {7'd0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
        chk("drain_valid", {7'd0, out_valid}, 8'h01);
        chk("drain_y", Y, 8'h08);

        // reset in the middle of a multiply discards it
        tick();
        issue(4'hC, 8'hFF, 8'hFF);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {7'd0, out_valid}, 8'h00);
        chk("mrst_y", Y, 8'h00);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_ready", {7'd0, in_ready}, 8'h01);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("mrst_no_stale", {7'd0, out_valid}, 8'h00);
        end

        // illegal opcode
        issue(4'hE, 8'h12, 8'h34);
        chk("ill_valid", {7'd0, out_valid}, 8'h01);
        chk("ill_y", Y, 8'h00);
        chk("ill_flags", flags(), 8'h11);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 32-bit combinational 3-bit-opcode ALU.
- Width is configurable and the opcode is widened to 4 bits; the original eight operations keep their encodings.
- Adds XOR, shifts, an iterative multiply and status flags, with valid/ready handshakes on both sides.
- Sits between the operand register file and the writeback stage of the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of 2).
- SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode present.
- in_ready  out  1  block can accept an operation.
- Op_code  in  4  operation select.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  Y and flags valid.
- out_ready  in  1  consumer accepts the result.
- Y  out  WIDTH  result.
- flag_z  out  1  Y == 0.
- flag_n  out  1  Y[WIDTH-1].
- flag_c  out  1  carry/borrow (see below).
- flag_v  out  1  signed overflow.
- flag_err  out  1  illegal opcode.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; out_valid=0; Y=0; all flags 0; multiply registers cleared.
  - in_ready=1 after reset release.
- Opcodes, all arithmetic modulo 2^WIDTH:
  - 0000 Y=A; 0001 A+B; 0010 A-B; 0011 A&B; 0100 A|B; 0101 A+1; 0110 A-1; 0111 Y=B.
  - 1000 A^B.
  - 1001 A<<B[SHW-1:0]; 1010 logical A>>B[SHW-1:0]; 1011 arithmetic A>>>B[SHW-1:0].
  - 1100 MUL: low WIDTH bits of unsigned A*B.
  - 1101-1111 illegal: Y=0, flag_err=1, flag_z=1.
- Flags:
  - flag_c:
    - ADD/INC: carry-out.
    - SUB/DEC: borrow (1 when A < subtrahend, unsigned).
    - MUL: 1 if the upper WIDTH product bits are nonzero.
    - All other ops: 0.
  - flag_v: signed overflow for ADD/SUB/INC/DEC; 0 otherwise.
  - flag_z, flag_n: computed on Y for every op.
  - All flags are registered with Y and held while out_valid=1.
- Handshake:
  - Transfer occurs on a cycle with valid & ready both high.
  - Y and flags stay stable while out_valid=1 && out_ready=0.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
- FSM:
  - IDLE:
    - Accept non-MUL: register result and flags; go to DONE. out_valid rises the cycle after acceptance (latency 1).
    - Accept MUL: latch A and B; clear the accumulator; load count=WIDTH; go to MUL.
  - MUL:
    - Each cycle: if multiplier LSB, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count--.
    - Accumulator is 2*WIDTH bits.
    - in_ready=0.
    - When count reaches 0: register result and flags; go to DONE.
    - MUL latency = WIDTH+1 cycles from acceptance to out_valid.
  - DONE:
    - out_valid=1.
    - On out_ready with no new acceptance: go to IDLE, out_valid=0 next cycle.
    - On out_ready with simultaneous acceptance: behave as IDLE acceptance. Back-to-back single-cycle ops sustain 1 op/cycle.
- Boundary conditions:
  - in_valid while in_ready=0 is ignored; the source must hold it.
  - Shift amount uses only B[SHW-1:0]; upper B bits are ignored.
  - MUL with A=0 or B=0 still takes the full WIDTH cycles.
  - rst_n asserted mid-MUL or in DONE: immediate return to reset state; pending result discarded.
  - Op_code, A, B are sampled only on the acceptance cycle.

Test Plan:
1. WIDTH=8. ADD A=8'hFF, B=8'h01 with out_ready=1 -> next cycle out_valid=1, Y=8'h00, z=1, c=1, v=0. Then ADD 8'h7F+8'h01 -> Y=8'h80, n=1, v=1, c=0.
2. WIDTH=8. SUB A=8'h00, B=8'h01 -> Y=8'hFF, c=1, n=1. DEC A=8'h80 -> Y=8'h7F, v=1.
3. WIDTH=8. SRA A=8'h90, B=8'hF3 (amount 3) -> Y=8'hF2. SHR same operands -> Y=8'h12. SHL A=8'h81, B=1 -> Y=8'h02.
4. WIDTH=8. MUL A=8'd20, B=8'd13 -> in_ready=0 for 8 cycles; out_valid 9 cycles after acceptance; Y=8'h04 (260 mod 256), c=1. MUL 8'd3*8'd5 -> Y=8'h0F, c=0.
5. Back-to-back: 4 single-cycle ops on consecutive cycles, out_ready=1 -> 4 results on consecutive cycles, in order. With out_ready=0 for 3 cycles, the first result is held stable and in_ready=0 throughout.
6. Opcode 4'b1110 -> Y=0, flag_err=1, z=1. Assert rst_n=0 mid-MUL -> out_valid=0 and Y=0 immediately; after release in_ready=1 and no stale result appears.
